// File: rtl/phy_rx_fifo_pkg.sv
// Shared constants and helpers for the PHY receive elastic buffer.
// Holds the default word width, depth, almost-full threshold and the drop-counter width.
package phy_rx_fifo_pkg;

  localparam int PHY_DATA_W     = 32;
  localparam int FIFO_DEPTH_DEF = 8;
  localparam int FIFO_AF_DEF    = 6;
  localparam int DROP_CNT_W     = 8;

  // Saturating increment: the drop counter holds at its maximum value instead of wrapping.
  function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/phy_fifo_mem.sv
// DEPTH x DATA_W register array for the PHY receive FIFO.
// One synchronous write port; one asynchronous read port that feeds the show-ahead head word.
module phy_fifo_mem
  import phy_rx_fifo_pkg::*;
#(
  parameter int DATA_W = PHY_DATA_W,
  parameter int DEPTH  = FIFO_DEPTH_DEF,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  // Storage is deliberately not reset; the top gates the output while empty.
  always_ff @(posedge clk) begin
    if (we) r_mem[waddr] <= wdata;
  end

  assign rdata = r_mem[raddr];

endmodule

// File: rtl/phy_rx_fifo.sv
// Show-ahead receive FIFO downstream of the PHY RX. There is no backpressure, so words that arrive while the FIFO is full are dropped.
// Optional macro PHY_RX_FIFO_DROPCNT_EN adds the drop_cnt port, a saturating count of dropped words.
module phy_rx_fifo
  import phy_rx_fifo_pkg::*;
#(
  parameter int DATA_W    = PHY_DATA_W,
  parameter int DEPTH     = FIFO_DEPTH_DEF,
  parameter int AF_THRESH = FIFO_AF_DEF,
  parameter int PW        = $clog2(DEPTH),
  parameter int CW        = $clog2(DEPTH) + 1
) (
  input  logic              clk_f,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in,
  input  logic              valid_in,
  input  logic              pop,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  output logic              full,
  output logic              almost_full,
  output logic [CW-1:0]     count,
  output logic              overflow
`ifdef PHY_RX_FIFO_DROPCNT_EN
  ,
  output logic [DROP_CNT_W-1:0] drop_cnt
`endif
);

  logic [PW-1:0]     r_wr_ptr;
  logic [PW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic              r_overflow;
  logic              w_empty;
  logic              w_full;
  logic              w_push;
  logic              w_pop_eff;
  logic              w_drop;
  logic [DATA_W-1:0] w_rdata;

  // Full and empty come from the registered count because the pointers are equal in both cases.
  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == CW'(DEPTH));
  assign w_pop_eff = pop && !w_empty;
  assign w_push    = valid_in && (!w_full || pop);
  assign w_drop    = valid_in && w_full && !pop;

  phy_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (PW)
  ) u_mem (
    .clk   (clk_f),
    .we    (w_push),
    .waddr (r_wr_ptr),
    .wdata (data_in),
    .raddr (r_rd_ptr),
    .rdata (w_rdata)
  );

  always_ff @(posedge clk_f or posedge reset) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push)    r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop_eff) r_rd_ptr <= r_rd_ptr + PW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop_eff);
      if (w_drop)    r_overflow <= 1'b1;
    end
  end

`ifdef PHY_RX_FIFO_DROPCNT_EN
  logic [DROP_CNT_W-1:0] r_drop_cnt;

  always_ff @(posedge clk_f or posedge reset) begin
    if (reset)       r_drop_cnt <= '0;
    else if (w_drop) r_drop_cnt <= sat_inc(r_drop_cnt);
  end

  assign drop_cnt = r_drop_cnt;
`endif

  assign valid_out   = !w_empty;
  assign data_out    = w_empty ? '0 : w_rdata;
  assign full        = w_full;
  assign almost_full = (r_count >= CW'(AF_THRESH));
  assign count       = r_count;
  assign overflow    = r_overflow;

endmodule

// File: tb/tb_phy_rx_fifo.sv
// Directed bench for phy_rx_fifo: table-driven push/pop vectors plus hand-written stream, reset and drop sequences.
// Build with or without PHY_RX_FIFO_DROPCNT_EN; the drop counter checks follow the macro.
module tb_phy_rx_fifo;

  logic        clk_f = 1'b0;
  logic        reset;
  logic [31:0] data_in;
  logic        valid_in;
  logic        pop;
  logic [31:0] data_out;
  logic        valid_out;
  logic        full;
  logic        almost_full;
  logic [3:0]  count;
  logic        overflow;
`ifdef PHY_RX_FIFO_DROPCNT_EN
  logic [7:0]  drop_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  phy_rx_fifo dut (
    .clk_f       (clk_f),
    .reset       (reset),
    .data_in     (data_in),
    .valid_in    (valid_in),
    .pop         (pop),
    .data_out    (data_out),
    .valid_out   (valid_out),
    .full        (full),
    .almost_full (almost_full),
    .count       (count),
    .overflow    (overflow)
`ifdef PHY_RX_FIFO_DROPCNT_EN
    ,
    .drop_cnt    (drop_cnt)
`endif
  );

  always #5 clk_f = ~clk_f;

  typedef struct {
    logic        vin;
    logic [31:0] din;
    logic        pop;
    int          cnt;
    logic        vld;
    logic [31:0] dout;
    logic        full;
    logic        af;
    logic        ovf;
    int          drops;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", nm, act, exp);
    end
  endtask

  task automatic step(input logic v, input logic [31:0] d, input logic p);
    valid_in = v;
    data_in  = d;
    pop      = p;
    @(posedge clk_f);
    #1;
  endtask

  task automatic do_reset();
    valid_in = 1'b0;
    data_in  = '0;
    pop      = 1'b0;
    reset    = 1'b1;
    @(posedge clk_f);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Stimulus: {vin, din, pop} -> {count, valid, data_out, full, almost_full, overflow, drops}
    vq.push_back('{1'b1, 32'hA5A5_0001, 1'b0, 1, 1'b1, 32'hA5A5_0001, 1'b0, 1'b0, 1'b0, 0});
    vq.push_back('{1'b1, 32'hA5A5_0002, 1'b0, 2, 1'b1, 32'hA5A5_0001, 1'b0, 1'b0, 1'b0, 0});
    vq.push_back('{1'b1, 32'hA5A5_0003, 1'b0, 3, 1'b1, 32'hA5A5_0001, 1'b0, 1'b0, 1'b0, 0});
    vq.push_back('{1'b1, 32'hA5A5_0004, 1'b0, 4, 1'b1, 32'hA5A5_0001, 1'b0, 1'b0, 1'b0, 0});
    vq.push_back('{1'b1, 32'hA5A5_0005, 1'b0, 5, 1'b1, 32'hA5A5_0001, 1'b0, 1'b0, 1'b0, 0});
    vq.push_back('{1'b1, 32'hA5A5_0006, 1'b0, 6, 1'b1, 32'hA5A5_0001, 1'b0, 1'b1, 1'b0, 0});
    vq.push_back('{1'b1, 32'hA5A5_0007, 1'b0, 7, 1'b1, 32'hA5A5_0001, 1'b0, 1'b1, 1'b0, 0});
    vq.push_back('{1'b1, 32'hA5A5_0008, 1'b0, 8, 1'b1, 32'hA5A5_0001, 1'b1, 1'b1, 1'b0, 0});
    vq.push_back('{1'b1, 32'hDEAD_BEEF, 1'b0, 8, 1'b1, 32'hA5A5_0001, 1'b1, 1'b1, 1'b1, 1});
    vq.push_back('{1'b1, 32'h1234_5678, 1'b1, 8, 1'b1, 32'hA5A5_0002, 1'b1, 1'b1, 1'b1, 1});
    vq.push_back('{1'b0, 32'h0,         1'b1, 7, 1'b1, 32'hA5A5_0003, 1'b0, 1'b1, 1'b1, 1});
    vq.push_back('{1'b0, 32'h0,         1'b1, 6, 1'b1, 32'hA5A5_0004, 1'b0, 1'b1, 1'b1, 1});
    vq.push_back('{1'b0, 32'h0,         1'b1, 5, 1'b1, 32'hA5A5_0005, 1'b0, 1'b0, 1'b1, 1});
    vq.push_back('{1'b0, 32'h0,         1'b1, 4, 1'b1, 32'hA5A5_0006, 1'b0, 1'b0, 1'b1, 1});
    vq.push_back('{1'b0, 32'h0,         1'b1, 3, 1'b1, 32'hA5A5_0007, 1'b0, 1'b0, 1'b1, 1});
    vq.push_back('{1'b0, 32'h0,         1'b1, 2, 1'b1, 32'hA5A5_0008, 1'b0, 1'b0, 1'b1, 1});
    vq.push_back('{1'b0, 32'h0,         1'b1, 1, 1'b1, 32'h1234_5678, 1'b0, 1'b0, 1'b1, 1});
    vq.push_back('{1'b0, 32'h0,         1'b1, 0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 1});
    vq.push_back('{1'b1, 32'h0000_00FF, 1'b1, 1, 1'b1, 32'h0000_00FF, 1'b0, 1'b0, 1'b1, 1});
    vq.push_back('{1'b0, 32'h0,         1'b1, 0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 1});
    vq.push_back('{1'b0, 32'h0,         1'b1, 0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 1});

    valid_in = 1'b0;
    data_in  = '0;
    pop      = 1'b0;
    reset    = 1'b1;
    #1;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_valid", 32'(valid_out), 32'd0);
    chk("rst_data", data_out, 32'h0);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_af", 32'(almost_full), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
`ifdef PHY_RX_FIFO_DROPCNT_EN
    chk("rst_drops", 32'(drop_cnt), 32'd0);
`endif
    @(posedge clk_f);
    #1;
    reset = 1'b0;

    // Fill, overflow, full push+pop, drain, empty push+pop
    for (int i = 0; i < vq.size(); i++) begin
      step(vq[i].vin, vq[i].din, vq[i].pop);
      chk($sformatf("v%0d_count", i), 32'(count), 32'(vq[i].cnt));
      chk($sformatf("v%0d_valid", i), 32'(valid_out), 32'(vq[i].vld));
      chk($sformatf("v%0d_data", i), data_out, vq[i].dout);
      chk($sformatf("v%0d_full", i), 32'(full), 32'(vq[i].full));
      chk($sformatf("v%0d_af", i), 32'(almost_full), 32'(vq[i].af));
      chk($sformatf("v%0d_ovf", i), 32'(overflow), 32'(vq[i].ovf));
`ifdef PHY_RX_FIFO_DROPCNT_EN
      chk($sformatf("v%0d_drops", i), 32'(drop_cnt), 32'(vq[i].drops));
`endif
    end

    // Streaming with pop every cycle, across several pointer wraps
    do_reset();
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 32'hC0DE_0000 + 32'(i), 1'b1);
      chk($sformatf("s%0d_data", i), data_out, 32'hC0DE_0000 + 32'(i));
      chk($sformatf("s%0d_count", i), 32'(count), 32'd1);
      chk($sformatf("s%0d_af", i), 32'(almost_full), 32'd0);
      chk($sformatf("s%0d_valid", i), 32'(valid_out), 32'd1);
    end
    step(1'b0, 32'h0, 1'b1);
    chk("s_end_count", 32'(count), 32'd0);
    chk("s_end_ovf", 32'(overflow), 32'd0);

    // Asynchronous reset in mid-stream with count=5 and overflow set
    do_reset();
    for (int i = 0; i < 9; i++) step(1'b1, 32'h6000_0000 + 32'(i), 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b1);
    step(1'b0, 32'h0, 1'b0);
    chk("m_count", 32'(count), 32'd5);
    chk("m_ovf", 32'(overflow), 32'd1);
    chk("m_data", data_out, 32'h6000_0003);
    @(negedge clk_f);
    #2;
    reset = 1'b1;
    #1;
    chk("ar_count", 32'(count), 32'd0);
    chk("ar_valid", 32'(valid_out), 32'd0);
    chk("ar_data", data_out, 32'h0);
    chk("ar_ovf", 32'(overflow), 32'd0);
    chk("ar_full", 32'(full), 32'd0);
    chk("ar_af", 32'(almost_full), 32'd0);
    @(posedge clk_f);
    #1;
    reset = 1'b0;
    step(1'b1, 32'hBEEF_0001, 1'b0);
    chk("ar_first_data", data_out, 32'hBEEF_0001);
    chk("ar_first_count", 32'(count), 32'd1);
    // Old entries 1..4 must not resurface after the reset
    step(1'b0, 32'h0, 1'b1);
    chk("ar_drain_count", 32'(count), 32'd0);
    chk("ar_drain_valid", 32'(valid_out), 32'd0);

`ifdef PHY_RX_FIFO_DROPCNT_EN
    // Drop counter saturates at 255
    do_reset();
    for (int i = 0; i < 8; i++) step(1'b1, 32'h7000_0000 + 32'(i), 1'b0);
    for (int i = 0; i < 300; i++) step(1'b1, 32'hFFFF_0000 + 32'(i), 1'b0);
    chk("sat_drops", 32'(drop_cnt), 32'd255);
    chk("sat_count", 32'(count), 32'd8);
    chk("sat_head", data_out, 32'h7000_0000);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
